mod14_updown_counter: RTL and testbench
=======================================

# mod14_updown_counter

Synchronous loadable mod-14 up/down counter that responds to the counter verification interface: it samples `reset`, `up_down`, `load` and `data_in` as driven by the source driver and presents `count` to the destination monitor. It is the DUT end of that protocol. Beyond the bare count it adds wrap pulses, a saturating wrap tally and an invalid-load error flag, so the bench can check boundary behaviour directly.

## Interface
- `MOD`, default 14: modulus. Legal range is 2..16. The count range is 0..MOD-1.
- `WRAP_W`, default 8: width of the wrap tally.
- `clock`, input, 1: single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset asserted). Release must be synchronous to `clock` at system level.
- `up_down`, input, 1: 1 = count up, 0 = count down.
- `load`, input, 1: 1 = load `data_in` this cycle.
- `data_in`, input, 4: load value. Legal values are 0..MOD-1.
- `err_clr`, input, 1: clears the sticky `load_err`.
- `count`, output, 4: registered counter value.
- `carry`, output, 1: one-cycle pulse when the count wraps from MOD-1 to 0.
- `borrow`, output, 1: one-cycle pulse when the count wraps from 0 to MOD-1.
- `load_err`, output, 1: sticky flag, set by an illegal load.
- `wrap_cnt`, output, WRAP_W: saturating count of carry plus borrow events.

## Operation
- **Reset** (`reset` = 0): immediately and asynchronously, regardless of clock:
  - `count` = 0
  - `carry` = 0, `borrow` = 0
  - `load_err` = 0
  - `wrap_cnt` = 0
- **Per-edge priority:** reset, then load, then count. There is no hold or enable; the counter advances every cycle unless a load occurs.
- **Legal load** (`load` = 1, `data_in` < MOD):
  - `count` takes `data_in`.
  - `carry` and `borrow` are 0, even if `data_in` equals 0 or MOD-1.
- **Illegal load** (`load` = 1, `data_in` >= MOD):
  - `count` holds its value.
  - `load_err` is set.
  - No carry or borrow.
  - `up_down` is ignored that cycle.
- **Up** (`load` = 0, `up_down` = 1):
  - If `count` = MOD-1: `count` goes to 0 and `carry` = 1.
  - Otherwise `count` + 1.
- **Down** (`load` = 0, `up_down` = 0):
  - If `count` = 0: `count` goes to MOD-1 and `borrow` = 1.
  - Otherwise `count` − 1.
- **Pulses:** `carry` and `borrow` are registered and cleared on every edge where no wrap occurs. They are never both 1.
- **Wrap tally:** `wrap_cnt` increments on each edge that produces a carry or borrow. It saturates at 2^WRAP_W − 1 and only reset clears it.
- **Error flag:** `load_err` is cleared by `err_clr` = 1 at an edge.
  - If an illegal load and `err_clr` occur at the same edge, set wins and `load_err` = 1.
- **Arithmetic:** 4-bit, modulo MOD. `count` never holds a value >= MOD.

## Timing
- All inputs are sampled at the rising edge of `clock`. Drivers change them 1 time unit after the edge.
- Latency is 1 cycle: inputs sampled at edge N appear on `count`, `carry`, `borrow`, `load_err` and `wrap_cnt` after edge N. The monitor sees them when it samples just before edge N+1.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-count overrides any in-flight load or wrap immediately.
- After reset deasserts, the first edge acts on the inputs present at that edge.
- `up_down` changes take effect at the very next edge with no turnaround cycle, including on the same edge as a wrap.
- There is no handshake: every cycle is a transaction.

## Test plan
- **Reset then count up:** assert reset, release, then `up_down` = 1 for 15 cycles.
  - Required: `count` goes 1, 2, …, 13, 0, 1.
  - `carry` is high only in the cycle `count` becomes 0.
  - `wrap_cnt` = 1.
- **Load then count down:** load 2, then `up_down` = 0 for 4 cycles.
  - Required: `count` goes 2, 1, 0, 13, 12.
  - `borrow` pulses when `count` becomes 13.
  - No pulse on the load cycle.
- **Illegal load:** with `count` = 5, load 14, then load 15.
  - Required: `count` stays 5 and `load_err` = 1.
  - Then `err_clr` together with load 15: `load_err` stays 1.
  - Then `err_clr` alone: `load_err` = 0.
- **Load at boundary:** load 13 with `up_down` = 1.
  - Required: `count` = 13 and `carry` = 0.
  - Next cycle: `count` = 0 and `carry` = 1.
- **Direction flip on wrap:** at `count` = 13, `up_down` = 1 for one cycle, then 0 for one cycle.
  - Required: `count` goes 0 with carry, then 13 with borrow.
  - `wrap_cnt` increases by 2.
- **Asynchronous reset mid-operation:** pull `reset` low between clock edges while counting, with `wrap_cnt` = 255.
  - Required: all outputs are 0 before the next edge.
  - Before the reset: keep wrapping to confirm `wrap_cnt` holds at 255.

Source files
------------

// File: rtl/mod14_updown_counter.sv
// Loadable modulo-MOD up/down counter with registered wrap pulses, a saturating
// wrap tally and a sticky error flag for out-of-range loads.
module mod14_updown_counter #(
  parameter int MOD    = 14,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              up_down,
  input  logic              load,
  input  logic [3:0]        data_in,
  input  logic              err_clr,
  output logic [3:0]        count,
  output logic              carry,
  output logic              borrow,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [3:0] MAX_VAL = 4'(MOD - 1);

  logic [3:0]        count_q, count_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  logic load_legal;
  logic load_illegal;

  // Five-bit compare so MOD = 16 still works with a 4-bit data_in.
  assign load_legal   = load && ({1'b0, data_in} < 5'(MOD));
  assign load_illegal = load && !load_legal;

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      if (load_legal) begin
        count_d = data_in;
      end
    end else if (up_down) begin
      if (count_q == MAX_VAL) begin
        count_d = 4'd0;
        carry_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else begin
      if (count_q == 4'd0) begin
        count_d  = MAX_VAL;
        borrow_d = 1'b1;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (load_illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    wrap_d = wrap_q;
    if ((carry_d || borrow_d) && (wrap_q != {WRAP_W{1'b1}})) begin
      wrap_d = wrap_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q  <= 4'd0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= '0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count    = count_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = err_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_mod14_updown_counter.sv
// Directed bench for mod14_updown_counter: hand-computed expected outputs,
// inputs driven on the falling edge and outputs sampled on the next falling edge.
module tb_mod14_updown_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       up_down;
  logic       load;
  logic [3:0] data_in;
  logic       err_clr;
  logic [3:0] count;
  logic       carry;
  logic       borrow;
  logic       load_err;
  logic [7:0] wrap_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mod14_updown_counter #(.MOD(14), .WRAP_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .up_down  (up_down),
    .load     (load),
    .data_in  (data_in),
    .err_clr  (err_clr),
    .count    (count),
    .carry    (carry),
    .borrow   (borrow),
    .load_err (load_err),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ec, input logic ecy,
                           input logic ebo, input logic eer, input logic [7:0] ew);
    check({tag, ".count"},    32'(count),    32'(ec));
    check({tag, ".carry"},    32'(carry),    32'(ecy));
    check({tag, ".borrow"},   32'(borrow),   32'(ebo));
    check({tag, ".load_err"}, 32'(load_err), 32'(eer));
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(ew));
  endtask

  // One transaction: drive, let one rising edge pass, sample on the falling edge.
  task automatic cyc(input string tag, input logic ud, input logic ld, input logic [3:0] din,
                     input logic clr, input logic [3:0] ec, input logic ecy, input logic ebo,
                     input logic eer, input logic [7:0] ew);
    up_down = ud;
    load    = ld;
    data_in = din;
    err_clr = clr;
    @(posedge clock);
    @(negedge clock);
    $display("cyc %-10s ud=%0d ld=%0d din=%0d clr=%0d -> count=%0d carry=%0d borrow=%0d err=%0d wrap=%0d",
             tag, ud, ld, din, clr, count, carry, borrow, load_err, wrap_cnt);
    check_all(tag, ec, ecy, ebo, eer, ew);
  endtask

  initial begin
    logic [7:0] ew;
    reset   = 1'b1;
    up_down = 1'b0;
    load    = 1'b0;
    data_in = 4'd0;
    err_clr = 1'b0;
    #1 reset = 1'b0;
    #2;
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clock);
    reset = 1'b1;

    // Count up through one wrap.
    for (int i = 1; i <= 13; i++) begin
      cyc("up", 1'b1, 1'b0, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    cyc("up_wrap", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    cyc("up_after", 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'd1);

    // Load then count down through a borrow.
    cyc("ld2",     1'b0, 1'b1, 4'd2, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 8'd1);
    cyc("dn1",     1'b0, 1'b0, 4'd0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 8'd1);
    cyc("dn0",     1'b0, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd1);
    cyc("dn_wrap", 1'b0, 1'b0, 4'd0, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 8'd2);
    cyc("dn12",    1'b0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 8'd2);

    // Illegal loads hold the count; set beats clear.
    cyc("ld5",      1'b1, 1'b1, 4'd5,  1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 8'd2);
    cyc("ld14",     1'b1, 1'b1, 4'd14, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 8'd2);
    cyc("ld15",     1'b0, 1'b1, 4'd15, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 8'd2);
    cyc("ld15_clr", 1'b1, 1'b1, 4'd15, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'd2);
    cyc("clr",      1'b1, 1'b0, 4'd0,  1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 8'd2);

    // Load at the top boundary gives no pulse; the next edge wraps.
    cyc("ld13",    1'b1, 1'b1, 4'd13, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0, 8'd2);
    cyc("ld13_up", 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'd3);

    // Legal load of 0 while counting down: no borrow.
    cyc("ld0", 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd3);

    // Direction flip on the wrap edge.
    cyc("flip_ld", 1'b1, 1'b1, 4'd13, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0, 8'd3);
    cyc("flip_up", 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'd4);
    cyc("flip_dn", 1'b0, 1'b0, 4'd0,  1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 8'd5);

    // Every cycle wraps while alternating; tally climbs to 255 and stays.
    ew = 8'd5;
    for (int i = 0; i < 260; i++) begin
      if (ew != 8'd255) ew = ew + 8'd1;
      if (i % 2 == 0) begin
        cyc("sat_up", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, ew);
      end else begin
        cyc("sat_dn", 1'b0, 1'b0, 4'd0, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, ew);
      end
    end
    check("sat_final", 32'(wrap_cnt), 32'd255);

    // Raise the error flag, then reset asynchronously between edges.
    cyc("pre_rst", 1'b1, 1'b1, 4'd15, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1, 8'd255);
    up_down = 1'b1;
    load    = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    load    = 1'b1;
    data_in = 4'd7;
    @(posedge clock);
    @(negedge clock);
    check_all("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    cyc("post_rst",  1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc("post_dn",   1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc("post_wrap", 1'b0, 1'b0, 4'd0, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
